wb_copy_engine: RTL and testbench
=================================

// Module: wb_copy_engine
// PURPOSE
//  Run-time programmable Wishbone-to-sink copy engine. Successor to the fixed flash->VRAM loader.
//  Reads word_count words from a Wishbone slave (e.g. flash_top) starting at src_addr.
//  Buffers them in a small FIFO and writes them to a VRAM-style write port starting at dst_addr.
//  Sink applies backpressure. Bus errors and timeouts are reported.
// PARAMETERS
//  ADDR_W      27    byte-address width, Wishbone and sink
//  DATA_W      32    word width; multiple of 8; address stride = DATA_W/8
//  CNT_W       16    width of word_count
//  FIFO_DEPTH  4     read-data buffer depth in words; power of 2, >=2
//  TIMEOUT     1023  max cycles stb may be held without ack/err before abort
// PORTS
//  clk_50MHz   in   1              single clock, all logic on posedge
//  reset_n     in   1              asynchronous, active-low reset
//  start       in   1              1-cycle request; sampled only in IDLE
//  src_addr    in   ADDR_W         first source byte address; latched on accepted start
//  dst_addr    in   ADDR_W         first sink byte address; latched on accepted start
//  word_count  in   CNT_W          words to copy; latched on accepted start
//  busy        out  1              high from cycle after accepted start until done
//  done        out  1              1-cycle completion pulse, success or abort
//  error       out  1              sticky abort flag; cleared by next accepted start
//  wb_cyc_o    out  1              Wishbone cycle
//  wb_stb_o    out  1              Wishbone strobe; equals wb_cyc_o
//  wb_we_o     out  1              constant 0 (read-only master)
//  wb_sel_o    out  DATA_W/8       constant all-ones
//  wb_adr_o    out  ADDR_W         read address
//  wb_dat_i    in   DATA_W         read data, valid with wb_ack_i
//  wb_ack_i    in   1              transfer acknowledge
//  wb_err_i    in   1              transfer error
//  sink_we     out  1              write request; held until accepted
//  sink_addr   out  ADDR_W         write address
//  sink_data   out  DATA_W         write data
//  sink_ready  in   1              sink accepts when sink_we && sink_ready at posedge
//  checksum    out  DATA_W         only with WB_COPY_CHECKSUM_EN
// BEHAVIOUR
//  Reset: all outputs 0; FIFO emptied; state IDLE.
//   Reset asserted mid-transfer aborts immediately; no done pulse.
//  All outputs registered.
//  Addresses advance by DATA_W/8 per word and wrap modulo 2^ADDR_W.
//  Read FSM states:
//   IDLE  -- start: latch args, clear error; word_count==0 -> DONE, else REQ.
//   REQ   -- cyc/stb high with wb_adr_o; at most 1 outstanding read.
//            ack only -> push wb_dat_i, drop cyc/stb next cycle, go GAP.
//            err, or err together with ack (err wins) -> ABORT.
//            stall counter reaches TIMEOUT -> ABORT.
//   GAP   -- 1 idle bus cycle.
//            All words read -> DRAIN.
//            FIFO has space for another word -> REQ.
//            Otherwise stay in GAP; no read issued while FIFO is full.
//   DRAIN -- wait until FIFO empty and last sink write accepted -> DONE.
//   ABORT -- drop cyc/stb, flush FIFO, drop sink_we, set error -> DONE.
//   DONE  -- done=1 for 1 cycle, busy=0 same cycle -> IDLE.
//  start seen outside IDLE is ignored, with no side effects.
//  Sink side runs concurrently with reads. It pops the FIFO into sink_data/sink_addr with sink_we=1.
//   sink_we/sink_addr/sink_data stay stable while sink_ready=0.
//   On acceptance the next word is presented the following cycle if available, else sink_we=0.
//   Back-to-back writes are supported, 1 per cycle.
//  Data order is preserved. No word is dropped or duplicated under any ready/ack pattern.
//  Same-cycle FIFO push and pop is legal at any fill level, including full.
// CONFIGURATION
//  WB_COPY_CHECKSUM_EN defined:
//   checksum = running sum modulo 2^DATA_W of words accepted by the sink.
//   Cleared on accepted start. Final when done pulses. Not cleared by abort.
//  WB_COPY_CHECKSUM_EN undefined: checksum port and adder absent; everything else identical.
// STRUCTURE
//  Package wb_copy_pkg holds: read-FSM state encoding; WORD_BYTES = DATA_W/8; SEL_ALL = all-ones.
//  Sub-module wb_copy_fifo: synchronous FIFO (DATA_W x FIFO_DEPTH) with push, pop, full, empty, flush.
//  Top level holds the FSM, address/count registers, timeout counter and sink register.
// TESTING
//  1 src=0x10000 dst=0x2000 count=4, ack 2 cycles after stb, sink_ready=1
//    -> reads 0x10000..0x1000C; sink writes 0x2000..0x200C with matching data.
//    -> one done pulse; error=0.
//  2 count=0 -> done the cycle after IDLE->DONE; wb_cyc_o never high; no sink_we.
//  3 count=8, sink_ready=0 for 20 cycles, then 1
//    -> reads stop with FIFO full (4 words); all 8 written in order.
//  4 slave never acks word 2
//    -> TIMEOUT cycles later: cyc drops, error=1, done pulses, only words 0-1 reach the sink.
//  5 wb_err_i with ack on word 1 -> abort as in 4.
//    -> a start pulsed during busy is ignored; next start clears error.
//  6 reset_n low mid-transfer -> all outputs 0 asynchronously; a fresh start completes test 1.
//    -> with WB_COPY_CHECKSUM_EN: data 1,2,3,4 gives checksum=10.

Source files
------------

// File: rtl/wb_copy_pkg.sv
// Shared definitions for the Wishbone-to-sink copy engine: read-FSM encoding,
// default geometry and the word stride / byte-select constants.
package wb_copy_pkg;

    localparam int ADDR_W_DEF     = 27;
    localparam int DATA_W_DEF     = 32;
    localparam int CNT_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 1023;

    localparam int WORD_BYTES = DATA_W_DEF / 8;
    localparam logic [WORD_BYTES-1:0] SEL_ALL = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ABORT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/wb_copy_if.sv
// Bus bundle of the copy engine: Wishbone read master side and the sink write port.
// Sink handshake: sink_we is the valid; address/data hold until a cycle with sink_ready, and the word transfers on that edge.
interface wb_copy_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [DATA_W/8-1:0]   wb_sel_o;
    logic [ADDR_W-1:0]     wb_adr_o;
    logic [DATA_W-1:0]     wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  sink_we;
    logic [ADDR_W-1:0]     sink_addr;
    logic [DATA_W-1:0]     sink_data;
    logic                  sink_ready;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output sink_we, sink_addr, sink_data,
        input  sink_ready
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  sink_we, sink_addr, sink_data,
        output sink_ready
    );
endinterface

// File: rtl/wb_copy_fifo.sv
// Read-data buffer: synchronous FIFO with flush; push and pop may coincide at any
// fill level, including full.
module wb_copy_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic              do_push, do_pop;

    assign full_o     = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/wb_copy_engine.sv
// Programmable copy engine: reads word_count words over Wishbone, buffers them and writes them to a sink.
// Optional WB_COPY_CHECKSUM_EN adds a running sum of words accepted by the sink.
module wb_copy_engine
    import wb_copy_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk_50MHz,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output state_t            dbg_state,
    wb_copy_if.master         bus
`ifdef WB_COPY_CHECKSUM_EN
    ,output logic [DATA_W-1:0] checksum
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    state_t            state_q;
    logic              cyc_q, busy_q, done_q, error_q;
    logic [ADDR_W-1:0] rd_addr_q, dst_q, sink_addr_q;
    logic [CNT_W-1:0]  rd_left_q;
    logic [TW-1:0]     tmo_q;
    logic              sink_we_q;
    logic [DATA_W-1:0] sink_data_q;

    logic              start_acc, push, pop, flush;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_data;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign push      = (state_q == ST_REQ) && bus.wb_ack_i && !bus.wb_err_i;
    assign flush     = (state_q == ST_ABORT);
    // Refill the sink register when it is empty or being accepted this cycle.
    assign pop       = !fifo_empty && (!sink_we_q || bus.sink_ready) && !flush;

    wb_copy_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk_50MHz),
        .rst_n      (reset_n),
        .flush_i    (flush),
        .push_i     (push),
        .push_data_i(bus.wb_dat_i),
        .pop_i      (pop),
        .pop_data_o (fifo_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = cyc_q;
    assign bus.wb_we_o   = 1'b0;
    assign bus.wb_sel_o  = '1;
    assign bus.wb_adr_o  = rd_addr_q;
    assign bus.sink_we   = sink_we_q;
    assign bus.sink_addr = sink_addr_q;
    assign bus.sink_data = sink_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign dbg_state     = state_q;

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cyc_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_left_q <= '0;
            tmo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rd_addr_q <= src_addr;
                        rd_left_q <= word_count;
                        error_q   <= 1'b0;
                        tmo_q     <= '0;
                        if (word_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_REQ;
                            cyc_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // err outranks a simultaneous ack: the word is not trusted.
                    if (bus.wb_err_i) begin
                        cyc_q   <= 1'b0;
                        state_q <= ST_ABORT;
                    end else if (bus.wb_ack_i) begin
                        cyc_q     <= 1'b0;
                        rd_addr_q <= rd_addr_q + STRIDE;
                        rd_left_q <= rd_left_q - CNT_W'(1);
                        state_q   <= ST_GAP;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        cyc_q   <= 1'b0;
                        state_q <= ST_ABORT;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (rd_left_q == '0) begin
                        state_q <= ST_DRAIN;
                    end else if (!fifo_full) begin
                        state_q <= ST_REQ;
                        cyc_q   <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !sink_we_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    error_q <= 1'b1;
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            dst_q       <= '0;
            sink_we_q   <= 1'b0;
            sink_addr_q <= '0;
            sink_data_q <= '0;
        end else begin
            if (start_acc) dst_q <= dst_addr;
            if (flush) begin
                sink_we_q <= 1'b0;
            end else if (pop) begin
                sink_we_q   <= 1'b1;
                sink_data_q <= fifo_data;
                sink_addr_q <= dst_q;
                dst_q       <= dst_q + STRIDE;
            end else if (bus.sink_ready) begin
                sink_we_q <= 1'b0;
            end
        end
    end

`ifdef WB_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
    assign checksum = csum_q;

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (sink_we_q && bus.sink_ready) begin
            csum_q <= csum_q + sink_data_q;
        end
    end
`endif
endmodule

// File: tb/tb_wb_copy_engine.sv
// Directed bench for wb_copy_engine: Wishbone slave model, sink monitor and a
// scoreboard of expected read addresses and sink writes.
module tb_wb_copy_engine;
    import wb_copy_pkg::*;

    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1023;

    logic              clk_50MHz = 1'b0;
    logic              reset_n   = 1'b0;
    logic              start     = 1'b0;
    logic [ADDR_W-1:0] src_addr  = '0;
    logic [ADDR_W-1:0] dst_addr  = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic              busy, done, error;
    state_t            dbg_state;
`ifdef WB_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    wb_copy_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_copy_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
        .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state),
        .bus       (bus)
`ifdef WB_COPY_CHECKSUM_EN
        ,.checksum (checksum)
`endif
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // scoreboard state
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0]        exp_rd_q[$];
    logic [ADDR_W+DATA_W-1:0] mon_e;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   rd_cnt = 0;
    int   cyc_run = 0;
    int   max_cyc_run = 0;
    int   bus_viol = 0;
    bit   cyc_seen = 0;
    bit   we_seen = 0;
    logic exp_err = 1'b0;

    // slave configuration
    int                ack_lat = 2;
    int                hang_word = -1;
    int                err_word = -1;
    logic [ADDR_W-1:0] cur_src = '0;
    logic [DATA_W-1:0] cur_base = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=0x%0h expected=none", name, act);
    endtask

    task automatic expect_words(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                                input logic [DATA_W-1:0] base, input int n_rd, input int n_sink);
        for (int i = 0; i < n_rd; i++) exp_rd_q.push_back(src + ADDR_W'(4 * i));
        for (int i = 0; i < n_sink; i++) exp_q.push_back({dst + ADDR_W'(4 * i), base + DATA_W'(i)});
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                               input logic [CNT_W-1:0] cnt);
        src_addr   = src;
        dst_addr   = dst;
        word_count = cnt;
        start      = 1'b1;
        @(posedge clk_50MHz); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < budget) begin
            @(posedge clk_50MHz); #1;
            n++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != c0), 64'd1);
        repeat (3) @(posedge clk_50MHz);
        #1;
        check({name, "_one_done"}, 64'(done_cnt), 64'(c0 + 1));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    // Wishbone slave: answers after ack_lat cycles of cyc; data = cur_base + word index
    initial begin
        int stall;
        int idx;
        logic [ADDR_W-1:0] off;
        stall = 0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = '0;
        forever begin
            @(posedge clk_50MHz); #1;
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            if (!reset_n || !bus.wb_cyc_o) begin
                stall = 0;
            end else begin
                stall++;
                off = bus.wb_adr_o - cur_src;
                idx = int'(off >> 2);
                if (stall >= ack_lat && idx != hang_word) begin
                    stall = 0;
                    if (exp_rd_q.size() == 0) fail_now("rd_unexpected", 64'(bus.wb_adr_o));
                    else check("rd_addr", 64'(bus.wb_adr_o), 64'(exp_rd_q.pop_front()));
                    bus.wb_ack_i = 1'b1;
                    if (idx == err_word) begin
                        bus.wb_err_i = 1'b1;
                    end else begin
                        bus.wb_dat_i = cur_base + DATA_W'(idx);
                        rd_cnt++;
                    end
                end
            end
        end
    end

    // monitor: sink acceptances, done pulses, bus invariants
    always @(negedge clk_50MHz) begin
        if (reset_n) begin
            if (bus.sink_we) we_seen = 1;
            if (bus.wb_cyc_o) begin
                cyc_seen = 1;
                cyc_run++;
                if (cyc_run > max_cyc_run) max_cyc_run = cyc_run;
            end else begin
                cyc_run = 0;
            end
            if (bus.wb_stb_o !== bus.wb_cyc_o || bus.wb_we_o !== 1'b0 || bus.wb_sel_o !== 4'hF)
                bus_viol++;
            if (bus.sink_we && bus.sink_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("sink_unexpected", {bus.sink_addr[31-DATA_W+ADDR_W-27:0], bus.sink_data});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sink_addr", 64'(bus.sink_addr), 64'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
                    check("sink_data", 64'(bus.sink_data), 64'(mon_e[DATA_W-1:0]));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_error", 64'(error), 64'(exp_err));
                check("done_busy", 64'(busy), 64'd0);
                check("done_sink_left", 64'(exp_q.size()), 64'd0);
                check("done_rd_left", 64'(exp_rd_q.size()), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int rd0;
        bus.sink_ready = 1'b1;

        // reset state
        idle_cycles(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
        check("rst_sink_we", 64'(bus.sink_we), 64'd0);
        check("rst_adr", 64'(bus.wb_adr_o), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        reset_n = 1'b1;
        idle_cycles(2);

        // 1: basic 4-word copy
        ack_lat = 2; cur_src = 27'h10000; cur_base = 32'hCAFE_0000; exp_err = 1'b0;
        expect_words(27'h10000, 27'h2000, 32'hCAFE_0000, 4, 4);
        pulse_start(27'h10000, 27'h2000, 16'd4);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done(200, "t1");
        check("t1_error", 64'(error), 64'd0);
        check("t1_state", 64'(dbg_state), 64'(ST_IDLE));

        // 2: zero-length copy
        cyc_seen = 0; we_seen = 0; c0 = done_cnt;
        pulse_start(27'h300, 27'h400, 16'd0);
        check("t2_done_now", 64'(done), 64'd1);
        check("t2_busy_now", 64'(busy), 64'd0);
        idle_cycles(1);
        check("t2_done_off", 64'(done), 64'd0);
        idle_cycles(3);
        check("t2_one_done", 64'(done_cnt), 64'(c0 + 1));
        check("t2_no_cyc", 64'(cyc_seen), 64'd0);
        check("t2_no_we", 64'(we_seen), 64'd0);

        // 3: sink backpressure, FIFO fills and reads stop
        bus.sink_ready = 1'b0; ack_lat = 1; cur_src = 27'h8000; cur_base = 32'h5000_0000;
        rd0 = rd_cnt;
        expect_words(27'h8000, 27'h9000, 32'h5000_0000, 8, 8);
        pulse_start(27'h8000, 27'h9000, 16'd8);
        idle_cycles(20);
        check("t3_reads_stalled", 64'(rd_cnt - rd0), 64'(DEPTH + 1));
        check("t3_state_gap", 64'(dbg_state), 64'(ST_GAP));
        check("t3_we_held", 64'(bus.sink_we), 64'd1);
        check("t3_addr_held", 64'(bus.sink_addr), 64'h9000);
        check("t3_data_held", 64'(bus.sink_data), 64'h5000_0000);
        bus.sink_ready = 1'b1;
        wait_done(200, "t3");

        // 4: slave hangs on word 2 -> timeout abort
        ack_lat = 2; hang_word = 2; cur_src = 27'h20000; cur_base = 32'h4444_0000;
        exp_err = 1'b1; max_cyc_run = 0;
        expect_words(27'h20000, 27'h3000, 32'h4444_0000, 2, 2);
        pulse_start(27'h20000, 27'h3000, 16'd4);
        wait_done(TIMEOUT + 200, "t4");
        check("t4_stall_len", 64'(max_cyc_run), 64'(TIMEOUT));
        check("t4_error", 64'(error), 64'd1);
        check("t4_cyc_low", 64'(bus.wb_cyc_o), 64'd0);
        hang_word = -1;

        // 5: err with ack on word 1; start during busy ignored
        err_word = 1; cur_src = 27'h30000; cur_base = 32'h5555_0000;
        expect_words(27'h30000, 27'h3800, 32'h5555_0000, 2, 1);
        pulse_start(27'h30000, 27'h3800, 16'd4);
        idle_cycles(2);
        check("t5_busy", 64'(busy), 64'd1);
        pulse_start(27'h0, 27'h5000, 16'd2);
        wait_done(200, "t5");
        check("t5_error", 64'(error), 64'd1);
        err_word = -1; exp_err = 1'b0;
        cur_src = 27'h40000; cur_base = 32'h6600_0000;
        expect_words(27'h40000, 27'h4800, 32'h6600_0000, 2, 2);
        pulse_start(27'h40000, 27'h4800, 16'd2);
        check("t5_error_cleared", 64'(error), 64'd0);
        wait_done(200, "t5b");

        // 6: asynchronous reset mid-transfer, then fresh copy
        cur_src = 27'h10000; cur_base = 32'h7700_0000;
        expect_words(27'h10000, 27'h2000, 32'h7700_0000, 4, 4);
        pulse_start(27'h10000, 27'h2000, 16'd4);
        idle_cycles(6);
        #3;
        reset_n = 1'b0;
        #1;
        c0 = done_cnt;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_cyc", 64'(bus.wb_cyc_o), 64'd0);
        check("t6_sink_we", 64'(bus.sink_we), 64'd0);
        check("t6_sink_addr", 64'(bus.sink_addr), 64'd0);
        check("t6_sink_data", 64'(bus.sink_data), 64'd0);
        check("t6_adr", 64'(bus.wb_adr_o), 64'd0);
        check("t6_state", 64'(dbg_state), 64'(ST_IDLE));
        exp_q.delete();
        exp_rd_q.delete();
        idle_cycles(3);
        check("t6_no_done", 64'(done_cnt), 64'(c0));
        reset_n = 1'b1;
        idle_cycles(2);
        cur_base = 32'd1;
        expect_words(27'h10000, 27'h2000, 32'd1, 4, 4);
        pulse_start(27'h10000, 27'h2000, 16'd4);
        wait_done(200, "t6");
`ifdef WB_COPY_CHECKSUM_EN
        check("t6_checksum", 64'(checksum), 64'd10);
`endif

        check("final_sink_left", 64'(exp_q.size()), 64'd0);
        check("bus_invariants", 64'(bus_viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
